// File: rtl/conv_pkg.sv
// Shared types and constants for the 3x3 convolution window reader.
package conv_pkg;

    localparam int DATA_W_DEFAULT = 32;
    localparam int KSIZE          = 3;
    localparam int CNT_W          = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    // Bit offset of window element (row i, column j) inside the flattened window bus.
    function automatic int win_idx(input int i, input int j, input int data_w);
        return data_w * (KSIZE * i + j);
    endfunction

endpackage

// File: rtl/line_delay_en.sv
// Enable-gated delay line: dout is the sample that entered DEPTH enabled shifts ago.
module line_delay_en #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [DEPTH-1:0][DATA_W-1:0] mem_q;
    logic [DEPTH-1:0][DATA_W-1:0] mem_d;

    // Shift one position per enabled cycle; hold otherwise.
    always_comb begin
        mem_d = mem_q;
        if (en) begin
            mem_d[0] = din;
            for (int k = 1; k < DEPTH; k++) begin
                mem_d[k] = mem_q[k-1];
            end
        end
    end

    // Storage register, cleared by reset so no stale pixels survive a restart.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign dout = mem_q[DEPTH-1];

endmodule

// File: rtl/conv_window_reader.sv
// Assembles 3x3 windows from a raster pixel stream using two line delays and
// a 3x3 shift array, with valid/ready flow control on both sides.
module conv_window_reader
    import conv_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [9*DATA_W-1:0]   win_data,
    output logic [CNT_W-1:0]      win_row,
    output logic [CNT_W-1:0]      win_col,
    output logic                  win_valid,
    input  logic                  win_ready,
    output logic                  done
);

    localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(IMG_W - 1);
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(IMG_H - 1);

    state_t state_q, state_d;
    logic [CNT_W-1:0] col_q, col_d;
    logic [CNT_W-1:0] row_q, row_d;
    logic [KSIZE-1:0][KSIZE-1:0][DATA_W-1:0] sr_q, sr_d;
    logic [9*DATA_W-1:0] win_data_q, win_data_d;
    logic [CNT_W-1:0]    win_row_q, win_row_d;
    logic [CNT_W-1:0]    win_col_q, win_col_d;
    logic                win_valid_q, win_valid_d;

    logic                accept;
    logic [DATA_W-1:0]   tap1;
    logic [DATA_W-1:0]   tap2;
    logic [KSIZE-1:0][DATA_W-1:0] col_in;

    // Input is taken only while streaming and when the output slot is free or being drained.
    assign in_ready = ((state_q == S_FILL) || (state_q == S_RUN)) && (!win_valid_q || win_ready);
    assign accept   = in_valid && in_ready;

    // Row r-1 tap: same column, one image row earlier.
    line_delay_en #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_line1 (
        .clk   (clk),
        .reset (reset),
        .en    (accept),
        .din   (in_data),
        .dout  (tap1)
    );

    // Row r-2 tap: fed from the row r-1 tap.
    line_delay_en #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_line2 (
        .clk   (clk),
        .reset (reset),
        .en    (accept),
        .din   (tap1),
        .dout  (tap2)
    );

    // New right-hand column of the window: top row from the oldest tap, bottom from the input.
    assign col_in[0] = tap2;
    assign col_in[1] = tap1;
    assign col_in[2] = in_data;

    // Next-state, counter, window-array and output-register logic.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        sr_d        = sr_q;
        win_data_d  = win_data_q;
        win_row_d   = win_row_q;
        win_col_d   = win_col_q;
        win_valid_d = win_valid_q;

        if (win_valid_q && win_ready) begin
            win_valid_d = 1'b0;
        end

        if (accept) begin
            if (col_q == LAST_COL) begin
                col_d = '0;
                row_d = row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end

            for (int i = 0; i < KSIZE; i++) begin
                for (int j = 0; j < KSIZE - 1; j++) begin
                    sr_d[i][j] = sr_q[i][j+1];
                end
                sr_d[i][KSIZE-1] = col_in[i];
            end

            // A full window exists only once two rows and two columns are behind us,
            // which also keeps every window inside a single row band.
            if ((row_q >= CNT_W'(2)) && (col_q >= CNT_W'(2))) begin
                win_valid_d = 1'b1;
                win_row_d   = row_q - CNT_W'(2);
                win_col_d   = col_q - CNT_W'(2);
                for (int i = 0; i < KSIZE; i++) begin
                    for (int j = 0; j < KSIZE; j++) begin
                        win_data_d[win_idx(i, j, DATA_W) +: DATA_W] = sr_d[i][j];
                    end
                end
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FILL;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            S_FILL: begin
                if (accept && (row_q == CNT_W'(1)) && (col_q == LAST_COL)) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (accept && (row_q == LAST_ROW) && (col_q == LAST_COL)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (win_valid_q && win_ready) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counter and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            col_q       <= '0;
            row_q       <= '0;
            sr_q        <= '0;
            win_data_q  <= '0;
            win_row_q   <= '0;
            win_col_q   <= '0;
            win_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            sr_q        <= sr_d;
            win_data_q  <= win_data_d;
            win_row_q   <= win_row_d;
            win_col_q   <= win_col_d;
            win_valid_q <= win_valid_d;
        end
    end

    assign win_data  = win_data_q;
    assign win_row   = win_row_q;
    assign win_col   = win_col_q;
    assign win_valid = win_valid_q;
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_conv_window_reader.sv
// Bench for conv_window_reader on a 5x5 image with pixel value 16*row + col.
module tb_conv_window_reader;

    localparam int DW = 32;
    localparam int W  = 5;
    localparam int H  = 5;
    localparam int CW = 9 * DW;

    typedef logic [CW-1:0] cval_t;

    typedef struct {
        logic [15:0]   row;
        logic [15:0]   col;
        logic [CW-1:0] data;
    } win_t;

    typedef struct {
        int vpct;
        int hold;
        int start_pix;
        int rst_pix;
        int exp_nwin;
    } scen_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] win_data;
    logic [15:0]   win_row;
    logic [15:0]   win_col;
    logic          win_valid;
    logic          win_ready;
    logic          done;

    win_t exp_q[$];
    win_t got_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    conv_window_reader #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .win_data  (win_data),
        .win_row   (win_row),
        .win_col   (win_col),
        .win_valid (win_valid),
        .win_ready (win_ready),
        .done      (done)
    );

    task automatic check(input string name, input cval_t act, input cval_t exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] pixval(input int p);
        return DW'(16 * (p / W) + (p % W));
    endfunction

    // Expected window whose top-left pixel is (top, left).
    function automatic win_t mk(input int top, input int left);
        win_t w;
        w.row  = 16'(top);
        w.col  = 16'(left);
        w.data = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                w.data[DW*(3*i+j) +: DW] = DW'(16 * (top + i) + (left + j));
            end
        end
        return w;
    endfunction

    task automatic run_frame(input int vpct, input int hold_n, input int start_pix,
                             input int rst_pix, input int exp_nwin);
        int    pix       = 0;
        int    nwin      = 0;
        int    first_acc = -1;
        int    last_hs   = -1;
        int    hold_left = hold_n;
        int    r;
        int    c;
        bit    armed     = 1'b0;
        bit    snap_ok   = 1'b0;
        bit    seen_done = 1'b0;
        bit    aborted   = 1'b0;
        cval_t snap_d;
        logic [31:0] snap_rc;
        win_t  g;
        win_t  e;

        exp_q.delete();
        got_q.delete();

        // start together with in_valid: nothing may be accepted while still IDLE
        start     = 1'b1;
        in_valid  = 1'b1;
        in_data   = pixval(0);
        win_ready = 1'b1;
        #1;
        check("start_no_accept", cval_t'(in_ready), cval_t'(0));
        @(posedge clk);
        #1;
        start    = 1'b0;
        in_valid = (vpct >= 100) || ($urandom_range(99) < vpct);

        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            if (win_valid && win_ready) begin
                g.row  = win_row;
                g.col  = win_col;
                g.data = win_data;
                got_q.push_back(g);
                nwin++;
                last_hs = cyc;
                if (exp_q.size() == 0) begin
                    check("win_expected", cval_t'(exp_q.size()), cval_t'(1));
                end else begin
                    e = exp_q.pop_front();
                    check("win_row", cval_t'(win_row), cval_t'(e.row));
                    check("win_col", cval_t'(win_col), cval_t'(e.col));
                    check("win_data", win_data, e.data);
                end
            end
            if (win_valid && !win_ready) begin
                check("hold_in_ready", cval_t'(in_ready), cval_t'(0));
                if (snap_ok) begin
                    check("hold_data", win_data, snap_d);
                    check("hold_rowcol", cval_t'({win_row, win_col}), cval_t'(snap_rc));
                end else begin
                    snap_d  = win_data;
                    snap_rc = {win_row, win_col};
                    snap_ok = 1'b1;
                end
                hold_left--;
            end
            if (done) begin
                check("done_timing", cval_t'(cyc), cval_t'(last_hs + 1));
                seen_done = 1'b1;
            end
            if (in_valid && in_ready) begin
                r = pix / W;
                c = pix % W;
                if (first_acc < 0) first_acc = cyc;
                if (r >= 2 && c >= 2) begin
                    exp_q.push_back(mk(r - 2, c - 2));
                    if (hold_n > 0) armed = 1'b1;
                end
                pix++;
            end
            if (seen_done) break;

            @(posedge clk);
            #1;
            if (rst_pix >= 0 && pix == rst_pix) begin
                reset     = 1'b1;
                start     = 1'b0;
                in_valid  = 1'b1;
                in_data   = pixval(pix);
                win_ready = 1'b1;
                @(posedge clk);
                #1;
                reset = 1'b0;
                @(negedge clk);
                check("rst_win_valid", cval_t'(win_valid), cval_t'(0));
                check("rst_in_ready", cval_t'(in_ready), cval_t'(0));
                check("rst_done", cval_t'(done), cval_t'(0));
                check("rst_win_data", win_data, cval_t'(0));
                aborted = 1'b1;
                break;
            end
            start     = (pix == start_pix);
            in_data   = pixval(pix);
            in_valid  = (pix < W * H) && ((vpct >= 100) || ($urandom_range(99) < vpct));
            win_ready = !(armed && hold_left > 0);
        end

        start = 1'b0;
        check("window_count", cval_t'(nwin), cval_t'(exp_nwin));
        if (rst_pix >= 0) begin
            check("reset_reached", cval_t'(aborted), cval_t'(1));
        end else begin
            check("frame_done", cval_t'(seen_done), cval_t'(1));
            check("scoreboard_empty", cval_t'(exp_q.size()), cval_t'(0));
            if (vpct >= 100 && hold_n == 0) begin
                check("cycles_first_acc_to_last_win", cval_t'(last_hs - first_acc + 1), cval_t'(26));
            end
            if (hold_n > 0) begin
                check("held_cycles", cval_t'(hold_n - hold_left), cval_t'(hold_n));
            end
            if (seen_done) begin
                @(posedge clk);
                #1;
                @(negedge clk);
                check("done_one_cycle", cval_t'(done), cval_t'(0));
                check("idle_in_ready", cval_t'(in_ready), cval_t'(0));
            end
        end
    endtask

    initial begin
        scen_t scen[6];
        int    lit_first[9];
        int    lit_last[9];
        win_t  wf;
        win_t  wl;

        // vpct, hold cycles, start-pulse pixel, reset pixel, windows expected
        scen[0] = '{100, 0, -1, -1, 9};   // full frame, back-to-back
        scen[1] = '{100, 4, -1, -1, 9};   // backpressure on the first window
        scen[2] = '{ 50, 0, -1, -1, 9};   // bursty input
        scen[3] = '{100, 0, -1, 12, 0};   // reset after 12 accepted pixels
        scen[4] = '{100, 0, -1, -1, 9};   // clean frame after the reset
        scen[5] = '{100, 0, 13, -1, 9};   // start pulsed while running

        lit_first = '{0, 1, 2, 16, 17, 18, 32, 33, 34};
        lit_last  = '{34, 35, 36, 50, 51, 52, 66, 67, 68};
        wf.row = 16'd0;
        wf.col = 16'd0;
        wl.row = 16'd2;
        wl.col = 16'd2;
        for (int k = 0; k < 9; k++) begin
            wf.data[DW*k +: DW] = DW'(lit_first[k]);
            wl.data[DW*k +: DW] = DW'(lit_last[k]);
        end

        reset     = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        win_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("reset_in_ready", cval_t'(in_ready), cval_t'(0));
        check("reset_win_valid", cval_t'(win_valid), cval_t'(0));
        check("reset_done", cval_t'(done), cval_t'(0));
        check("reset_win_data", win_data, cval_t'(0));
        check("reset_win_row", cval_t'(win_row), cval_t'(0));
        check("reset_win_col", cval_t'(win_col), cval_t'(0));

        for (int s = 0; s < 6; s++) begin
            run_frame(scen[s].vpct, scen[s].hold, scen[s].start_pix,
                      scen[s].rst_pix, scen[s].exp_nwin);
            if (got_q.size() == 9) begin
                check($sformatf("s%0d_first_rowcol", s),
                      cval_t'({got_q[0].row, got_q[0].col}), cval_t'({wf.row, wf.col}));
                check($sformatf("s%0d_first_data", s), got_q[0].data, wf.data);
                check($sformatf("s%0d_last_rowcol", s),
                      cval_t'({got_q[8].row, got_q[8].col}), cval_t'({wl.row, wl.col}));
                check($sformatf("s%0d_last_data", s), got_q[8].data, wl.data);
                for (int k = 0; k < 9; k++) begin
                    check($sformatf("s%0d_left_le2_%0d", s, k),
                          cval_t'(got_q[k].col <= 16'd2), cval_t'(1));
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
